// File: rtl/mux_pkg.sv
// Shared encodings and sizing helpers for the scanning multiplexer family.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  // Select/index width for n channels, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mask_next_sel.sv
// Combinational next-set-bit finder: lowest set bit strictly above cur,
// wrapping to the lowest set bit overall when none exists above.
module mask_next_sel
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 8,
  localparam int unsigned SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next,
  output logic [SEL_W-1:0] first,
  output logic             wrapped,
  output logic             any
);

  logic [SEL_W-1:0] above;
  logic             above_found;

  // Descending walk so the last hit is the lowest qualifying index.
  always_comb begin
    above       = '0;
    above_found = 1'b0;
    first       = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = SEL_W'(i);
        if (SEL_W'(i) > cur) begin
          above       = SEL_W'(i);
          above_found = 1'b1;
        end
      end
    end
  end

  assign any     = |mask;
  assign next    = above_found ? above : first;
  assign wrapped = any && !above_found;

endmodule

// File: rtl/mux_scan_n.sv
// N-channel W-bit registered multiplexer with manual select and a
// round-robin scan mode that dwells on each enabled channel.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 8,
  parameter  int unsigned W     = 1,
  parameter  int unsigned DWELL = 1,
  localparam int unsigned SEL_W = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] I,
  input  logic [SEL_W-1:0]  Sel,
  input  logic              Mode,
  input  logic              En,
  input  logic [N_CH-1:0]   Mask,
  output logic [W-1:0]      F,
  output logic              F_valid,
  output logic [SEL_W-1:0]  Ch,
  output logic              Wrap
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     f_q, f_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             wrap_q, wrap_d;

  logic [SEL_W-1:0] nxt_idx;
  logic [SEL_W-1:0] first_idx;
  logic             nxt_wrapped;
  logic             mask_any;
  logic             cur_on;

  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] data,
                                        input logic [SEL_W-1:0]  idx);
    logic [W-1:0] res;
    res = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (SEL_W'(k) == idx) res = data[k*W +: W];
    end
    return res;
  endfunction

  mask_next_sel #(
    .N_CH(N_CH)
  ) u_next (
    .mask   (Mask),
    .cur    (ptr_q),
    .next   (nxt_idx),
    .first  (first_idx),
    .wrapped(nxt_wrapped),
    .any    (mask_any)
  );

  // A cleared bit under the pointer forces an early advance.
  assign cur_on = |(Mask & (N_CH'(1'b1) << ptr_q));

  // Next-state and output decode; a zero counter marks a fresh scan entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    wrap_d  = 1'b0;
    if (En) begin
      if (Mode == MODE_MANUAL) begin
        state_d = ST_MANUAL;
        cnt_d   = '0;
        ch_d    = Sel;
        if (32'(Sel) < N_CH) begin
          f_d     = pick(I, Sel);
          valid_d = 1'b1;
        end else begin
          f_d     = '0;
          valid_d = 1'b0;
        end
      end else begin
        state_d = ST_SCAN;
        if (!mask_any) begin
          f_d     = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else begin
          if (state_q == ST_MANUAL || cnt_q == '0) begin
            ptr_d = first_idx;
            cnt_d = CNT_W'(1);
          end else if (cnt_q >= CNT_W'(DWELL) || !cur_on) begin
            ptr_d  = nxt_idx;
            cnt_d  = CNT_W'(1);
            wrap_d = nxt_wrapped;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          f_d     = pick(I, ptr_d);
          ch_d    = ptr_d;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      wrap_q  <= wrap_d;
    end
  end

  assign F       = f_q;
  assign F_valid = valid_q;
  assign Ch      = ch_q;
  assign Wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench: three mux_scan_n configurations against a list-based
// reference model, with directed scenarios followed by random traffic.
module tb_mux_scan_n;

  typedef struct {
    bit scan;
    bit resume;
    int ptr;
    int cnt;
    int f;
    bit valid;
    int ch;
    bit wrap;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode;
  logic [7:0] ab_i, ab_mask;
  logic [2:0] ab_sel;
  logic [19:0] c_i;
  logic [2:0] c_sel;
  logic [4:0] c_mask;

  logic       a_f, a_v, a_wr, b_f, b_v, b_wr, c_v, c_wr;
  logic [2:0] a_ch, b_ch, c_ch;
  logic [3:0] c_f;

  int   checks = 0;
  int   failures = 0;
  mdl_t ma, mb, mc;
  int   exp_ch[9] = '{1, 1, 2, 2, 4, 4, 7, 7, 1};
  int   exp_f[9]  = '{1, 1, 0, 0, 0, 0, 1, 1, 1};
  bit   found;
  int   hold_f, hold_ch;
  bit   hold_v;

  mux_scan_n #(.N_CH(8), .W(1), .DWELL(2)) u_a (
    .clk(clk), .rst(rst), .I(ab_i), .Sel(ab_sel), .Mode(mode), .En(en),
    .Mask(ab_mask), .F(a_f), .F_valid(a_v), .Ch(a_ch), .Wrap(a_wr));

  mux_scan_n #(.N_CH(8), .W(1), .DWELL(4)) u_b (
    .clk(clk), .rst(rst), .I(ab_i), .Sel(ab_sel), .Mode(mode), .En(en),
    .Mask(ab_mask), .F(b_f), .F_valid(b_v), .Ch(b_ch), .Wrap(b_wr));

  mux_scan_n #(.N_CH(5), .W(4), .DWELL(1)) u_c (
    .clk(clk), .rst(rst), .I(c_i), .Sel(c_sel), .Mode(mode), .En(en),
    .Mask(c_mask), .F(c_f), .F_valid(c_v), .Ch(c_ch), .Wrap(c_wr));

  function automatic int chan(input logic [63:0] d, input int w, input int k);
    logic [63:0] t;
    t = d >> (k * w);
    return int'(t & ((64'd1 << w) - 64'd1));
  endfunction

  // Reference: channel list rebuilt from the mask every cycle.
  function automatic mdl_t mstep(input mdl_t s, input int n, input int w,
                                 input int dwell, input logic [63:0] data,
                                 input int sel, input bit md, input bit e,
                                 input logic [63:0] mask, input bit r);
    mdl_t o;
    int   live[$];
    int   nxt;
    o = s;
    o.wrap = 1'b0;
    if (r) begin
      o = '{default: 0};
      return o;
    end
    if (!e) return o;
    if (!md) begin
      o.scan = 0; o.resume = 0; o.cnt = 0; o.ch = sel;
      o.valid = (sel < n);
      o.f = o.valid ? chan(data, w, sel) : 0;
      return o;
    end
    for (int k = 0; k < n; k++) if (mask[k]) live.push_back(k);
    if (live.size() == 0) begin
      o.scan = 1; o.resume = 1; o.f = 0; o.valid = 0; o.cnt = 0;
      return o;
    end
    if (!s.scan || s.resume) begin
      o.ptr = live[0];
      o.cnt = 1;
    end else if (s.cnt >= dwell || !mask[s.ptr]) begin
      nxt = -1;
      foreach (live[j]) if (nxt < 0 && live[j] > s.ptr) nxt = live[j];
      if (nxt < 0) begin
        nxt = live[0];
        o.wrap = 1'b1;
      end
      o.ptr = nxt;
      o.cnt = 1;
    end else begin
      o.cnt = s.cnt + 1;
    end
    o.scan = 1; o.resume = 0; o.ch = o.ptr; o.valid = 1;
    o.f = chan(data, w, o.ptr);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    ma = mstep(ma, 8, 1, 2, 64'(ab_i), int'(ab_sel), mode, en, 64'(ab_mask), rst);
    mb = mstep(mb, 8, 1, 4, 64'(ab_i), int'(ab_sel), mode, en, 64'(ab_mask), rst);
    mc = mstep(mc, 5, 4, 1, 64'(c_i), int'(c_sel), mode, en, 64'(c_mask), rst);
    chk({tag, ".a.f"},  32'(a_f),  32'(ma.f));
    chk({tag, ".a.v"},  32'(a_v),  32'(ma.valid));
    chk({tag, ".a.ch"}, 32'(a_ch), 32'(ma.ch));
    chk({tag, ".a.wr"}, 32'(a_wr), 32'(ma.wrap));
    chk({tag, ".b.f"},  32'(b_f),  32'(mb.f));
    chk({tag, ".b.v"},  32'(b_v),  32'(mb.valid));
    chk({tag, ".b.ch"}, 32'(b_ch), 32'(mb.ch));
    chk({tag, ".b.wr"}, 32'(b_wr), 32'(mb.wrap));
    chk({tag, ".c.f"},  32'(c_f),  32'(mc.f));
    chk({tag, ".c.v"},  32'(c_v),  32'(mc.valid));
    chk({tag, ".c.ch"}, 32'(c_ch), 32'(mc.ch));
    chk({tag, ".c.wr"}, 32'(c_wr), 32'(mc.wrap));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    rst = 1'b1; en = 1'b1; mode = 1'b0;
    ab_i = 8'h00; ab_mask = 8'h00; ab_sel = 3'd0;
    c_i = 20'h0; c_sel = 3'd0; c_mask = 5'h0;
    step("rst");
    chk("rst.a.f", 32'(a_f), 32'd0);
    chk("rst.c.ch", 32'(c_ch), 32'd0);
    step("rst");
    rst = 1'b0;

    // Manual sweep, including out-of-range selects on the 5-channel instance.
    ab_i = 8'b10101010;
    c_i  = {4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
    for (int s = 0; s < 8; s++) begin
      ab_sel = 3'(s);
      c_sel  = 3'(s);
      step("man");
      chk("man.sweep.f", 32'(a_f), 32'(s % 2));
      chk("man.sweep.ch", 32'(a_ch), 32'(s));
      chk("man.sweep.v", 32'(a_v), 32'd1);
      if (s == 3) begin
        chk("wide.sel3.f", 32'(c_f), 32'hD);
        chk("wide.sel3.v", 32'(c_v), 32'd1);
      end
      if (s == 6) begin
        chk("wide.sel6.f", 32'(c_f), 32'd0);
        chk("wide.sel6.v", 32'(c_v), 32'd0);
      end
    end

    // Scan over a sparse mask.
    ab_mask = 8'b10010110;
    c_mask  = 5'b10110;
    mode    = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step("scan");
      chk("scan.seq.ch", 32'(a_ch), 32'(exp_ch[i]));
      chk("scan.seq.f", 32'(a_f), 32'(exp_f[i]));
      chk("scan.seq.wr", 32'(a_wr), (i == 8) ? 32'd1 : 32'd0);
    end

    ab_mask = 8'h00;
    step("empty");
    chk("empty.f", 32'(a_f), 32'd0);
    chk("empty.v", 32'(a_v), 32'd0);

    ab_mask = 8'b00001000;
    for (int i = 0; i < 6; i++) begin
      step("single");
      chk("single.ch", 32'(a_ch), 32'd3);
      chk("single.wr", 32'(a_wr), (i > 0 && i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Clear the dwelling channel partway through a 4-cycle dwell.
    mode = 1'b0;
    ab_mask = 8'b10010110;
    step("mid");
    mode = 1'b1;
    step("mid");
    step("mid");
    chk("mid.pre.ch", 32'(b_ch), 32'd1);
    ab_mask = 8'b10010100;
    step("mid");
    chk("mid.adv.ch", 32'(b_ch), 32'd2);
    chk("mid.adv.wr", 32'(b_wr), 32'd0);

    // Reset landing on a wrap cycle.
    ab_mask = 8'b10010110;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step("seek");
      if (a_wr === 1'b1) found = 1'b1;
    end
    chk("seek.wrap", 32'(found), 32'd1);
    rst = 1'b1;
    step("rstwrap");
    chk("rstwrap.f", 32'(a_f), 32'd0);
    chk("rstwrap.v", 32'(a_v), 32'd0);
    chk("rstwrap.ch", 32'(a_ch), 32'd0);
    chk("rstwrap.wr", 32'(a_wr), 32'd0);
    rst = 1'b0;

    // Freeze with En low while inputs keep moving.
    step("pre_en");
    step("pre_en");
    step("pre_en");
    hold_f = ma.f; hold_ch = ma.ch; hold_v = ma.valid;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ab_i = ~ab_i;
      ab_mask = 8'($urandom);
      step("en_off");
      chk("en_off.f", 32'(a_f), 32'(hold_f));
      chk("en_off.ch", 32'(a_ch), 32'(hold_ch));
      chk("en_off.v", 32'(a_v), 32'(hold_v));
      chk("en_off.wr", 32'(a_wr), 32'd0);
    end
    en = 1'b1;

    // Random traffic; masks change occasionally so dwells complete.
    for (int i = 0; i < 400; i++) begin
      ab_i  = 8'($urandom);
      c_i   = 20'($urandom);
      ab_sel = 3'($urandom);
      c_sel  = 3'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        ab_mask = 8'($urandom) & 8'($urandom);
        c_mask  = 5'($urandom);
      end
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 39) == 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output.
- Supports two modes:
  - Manual mode: an external select drives the output, as in the fixed 8:1 mux.
  - Scan mode: an internal round-robin sequencer walks the enabled channels, dwells a programmable number of cycles on each, and flags wrap-around.
- Sits in front of shared observation and serialisation logic that samples many single-bit or narrow sources over one path.

Parameters:
- N_CH, 8, number of input channels (2..64).
- W, 1, width of each channel in bits.
- DWELL, 1, cycles F holds each channel in scan mode (1..255).
- SEL_W, derived localparam = max(1, clog2(N_CH)), select/index width. Not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- I  input  N_CH*W  packed channel data; channel k occupies bits [k*W +: W].
- Sel  input  SEL_W  channel select, used in manual mode only.
- Mode  input  1  0 = manual, 1 = scan.
- En  input  1  global enable; when low, all registers hold.
- Mask  input  N_CH  per-channel enable for scan mode; bit k = 1 includes channel k.
- F  output  W  registered selected data.
- F_valid  output  1  F holds a legal channel's data.
- Ch  output  SEL_W  index of the channel currently presented on F.
- Wrap  output  1  one-cycle pulse when the scan pointer wraps to the lowest enabled channel.

Behaviour:
- Reset (rst = 1 at a clock edge, overrides everything including En):
  - F = 0, F_valid = 0, Ch = 0, Wrap = 0.
  - Scan pointer = 0, dwell counter = 0, state = MANUAL.
- En = 0: F, F_valid, Ch, pointer and counter hold; Wrap forced to 0.
- State machine has two states: MANUAL and SCAN. State tracks Mode, registered; each edge with En = 1 uses the current Mode value.
- Manual mode (Mode = 0, En = 1):
  - Latency is 1 cycle: F <= I[Sel], Ch <= Sel, F_valid <= 1.
  - If Sel >= N_CH (only possible when N_CH is not a power of 2): F <= 0, Ch <= Sel, F_valid <= 0.
  - Wrap = 0.
- Entering SCAN (first edge with Mode = 1 after MANUAL or reset):
  - Pointer loads the lowest set Mask bit.
  - F <= I[that channel], Ch <= that channel, F_valid <= 1.
  - Dwell counter <= 1; no Wrap pulse.
- In SCAN:
  - Each edge with En = 1 re-samples F <= I[pointer], so F tracks live input data on the current channel.
  - When the dwell counter reaches DWELL, the pointer advances to the next set Mask bit strictly above the current one and the counter resets to 1. Otherwise the counter increments.
  - If no set bit exists above the current one, the pointer wraps to the lowest set bit and Wrap = 1 for exactly that cycle, coincident with the first F of the new channel.
  - A single enabled channel: the pointer stays put, and Wrap pulses every DWELL cycles.
  - Mask is sampled live. If the current channel is cleared mid-dwell, the pointer advances on the next edge regardless of the counter.
  - Mask = 0: F <= 0, F_valid <= 0, pointer and Ch hold, Wrap = 0. Scan resumes from the lowest set bit once Mask becomes non-zero.
- Mode 1 -> 0 takes effect on the next edge: manual selection, counter cleared.
- rst asserted mid-dwell or mid-wrap forces full reset values on that edge. Wrap never pulses on the reset edge.

Decomposition:
- Shared package mux_pkg holds:
  - mode encodings MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1;
  - state enum {ST_MANUAL, ST_SCAN};
  - a clog2-based function for SEL_W.
- One sub-module, mask_next_sel: combinational next-set-bit finder over Mask, given the current index. Outputs next index, wrapped flag and any-set flag. Reused by later arbiter blocks.

Test Plan:
- Manual sweep: N_CH=8, W=1, I = 8'b10101010, Mode=0, Sel 0..7 one per cycle -> F = 0,1,0,1,0,1,0,1, each one cycle after its Sel; F_valid = 1; Ch = Sel.
- Scan with mask: DWELL=2, Mask = 8'b10010110, I = 8'hAA, Mode=1:
  - Ch sequence 1,1,2,2,4,4,7,7,1…
  - F = 1,1,0,0,0,0,1,1,1…
  - Wrap high only on the cycle Ch returns to 1.
- Empty and single mask:
  - Mask = 0 in scan -> F_valid = 0 and F = 0 within 1 cycle.
  - Mask = 8'b00001000 -> Ch = 3 constant, Wrap every DWELL cycles.
- Mid-dwell mask change: DWELL=4, clear the current channel's Mask bit at dwell count 2 -> pointer advances on the next edge.
- Reset and enable:
  - rst asserted during the Wrap cycle -> next edge F = 0, F_valid = 0, Ch = 0, Wrap = 0.
  - En = 0 for 3 cycles -> all outputs frozen.
- Wide, non-power-of-2: N_CH=5, W=4, I = {4'hE,4'hD,4'hC,4'hB,4'hA}:
  - Sel = 3 -> F = 4'hD, F_valid = 1.
  - Sel = 6 -> F = 0, F_valid = 0.
